// File: rtl/pc_seq_if.sv
// Fetch-side bundle between the PC sequencer, instruction memory and IF/ID.
// Exception redirect signals exist only when PC_EXCEPTION_EN is defined.
interface pc_seq_if;
`ifdef PC_EXCEPTION_EN
  logic        exc_req_i;
  logic [31:0] exc_target_i;
`endif
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_4_o;
  logic [31:0] inst_o;
  logic        if_valid_o;
  logic        flush_o;

  modport master (
`ifdef PC_EXCEPTION_EN
    input  exc_req_i, exc_target_i,
`endif
    input  stall_i, branch_i, branch_target_i, imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, pc_o, pc_plus_4_o, inst_o, if_valid_o, flush_o
  );

  modport slave (
`ifdef PC_EXCEPTION_EN
    output exc_req_i, exc_target_i,
`endif
    output stall_i, branch_i, branch_target_i, imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, pc_o, pc_plus_4_o, inst_o, if_valid_o, flush_o
  );
endinterface

// File: rtl/pc_seq.sv
// Fetch-stage PC sequencer: sequential stepping, redirects, stalls and the imem handshake.
// Define PC_EXCEPTION_EN to add exception redirects with priority over branches.
module pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst_n,
  pc_seq_if.master bus
);
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_tgt;
  logic [31:0] inst_q;
  logic        pend;

  logic        redir;
  logic [31:0] tgt;
  logic        ack;

  always_comb begin
    redir = bus.branch_i;
    tgt   = bus.branch_target_i;
`ifdef PC_EXCEPTION_EN
    if (bus.exc_req_i) begin
      redir = 1'b1;
      tgt   = bus.exc_target_i;
    end
`endif
    tgt[1:0] = 2'b00;
  end

  assign ack = (state == FETCH) && bus.imem_ack_i;

  assign bus.imem_req_o  = (state == FETCH);
  assign bus.imem_addr_o = pc;
  assign bus.pc_o        = pc;
  assign bus.pc_plus_4_o = pc + 32'd4;
  assign bus.flush_o     = redir;
  // An ack that retires a pending redirect carries wrong-path data.
  assign bus.if_valid_o  = ((state == HOLD) && !redir) || (ack && !redir && !pend);
  assign bus.inst_o      = ack ? bus.imem_rdata_i : inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= 32'd0;
      inst_q   <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (redir) pc <= tgt;
        end
        FETCH: begin
          if (ack) begin
            if (redir) begin
              pc   <= tgt;
              pend <= 1'b0;
            end else if (pend) begin
              pc   <= pend_tgt;
              pend <= 1'b0;
            end else begin
              inst_q <= bus.imem_rdata_i;
              if (bus.stall_i) state <= HOLD;
              else             pc    <= pc + 32'd4;
            end
          end else if (redir) begin
            // Address must stay stable until ack, so park the target.
            pend     <= 1'b1;
            pend_tgt <= tgt;
          end
        end
        HOLD: begin
          if (redir) begin
            pc    <= tgt;
            state <= FETCH;
          end else if (!bus.stall_i) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule
